// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed display scanner.
// Holds the scan state enum, index-width function and blank patterns.
package display_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [15:0] ALL_LOW  = 16'h0000;
  localparam logic [15:0] ALL_HIGH = 16'hFFFF;

  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_sel_next.sv
// Rotating priority search: first enabled digit at or above start,
// wrapping modulo N. Purely combinational.
module digit_sel_next
  import display_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  en,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] nxt,
  output logic          found
);

  int j;
  logic [IW-1:0] jj;

  always_comb begin
    nxt   = start;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && en[jj]) begin
        nxt   = jj;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed display scanner: BLANK/DRIVE FSM with one dwell counter.
// Optional PWM dimming with DISPLAY_SCAN_BRIGHTNESS_EN (adds bright).
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SEG_W            = 7,
  parameter int DWELL_CYCLES     = 1024,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
  input  logic [3:0]                  bright,
`endif
  input  logic [NUM_DIGITS*SEG_W-1:0] disp,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic [clog2w(NUM_DIGITS)-1:0] digit_idx,
  output logic                        frame_tick
);

  localparam int IW   = clog2w(NUM_DIGITS);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (clog2w(MAXC) < 4) ? 4 : clog2w(MAXC);

  localparam logic [SEG_W-1:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? ALL_HIGH[SEG_W-1:0] : ALL_LOW[SEG_W-1:0];
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? ALL_HIGH[NUM_DIGITS-1:0]
                            : ALL_LOW[NUM_DIGITS-1:0];

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d, start, nxt;
  logic [SEG_W-1:0] lat, lat_d;
  logic [NUM_DIGITS-1:0] onehot_d;
  logic tick_d, found, lit_d;

  // BLANK end keeps the current digit if still enabled; DRIVE end moves on.
  always_comb begin
    start = idx;
    if (state == ST_DRIVE)
      start = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  digit_sel_next #(
    .N  (NUM_DIGITS),
    .IW (IW)
  ) u_sel (
    .en    (digit_en),
    .start (start),
    .nxt   (nxt),
    .found (found)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    lat_d   = lat;
    tick_d  = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_d = '0;
          if (found) begin
            state_d = ST_DRIVE;
            idx_d   = nxt;
            lat_d   = disp[nxt*SEG_W +: SEG_W];
          end
        end
      end
      ST_DRIVE: begin
        if (cnt == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          if (found) idx_d = nxt;
          tick_d  = ((found ? nxt : idx) <= idx);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    onehot_d = NUM_DIGITS'(1) << idx_d;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    lit_d = (state_d == ST_DRIVE) && (cnt_d[3:0] <= bright);
`else
    lit_d = (state_d == ST_DRIVE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      lat        <= '0;
      frame_tick <= 1'b0;
      anode      <= ANODE_OFF;
      seg        <= SEG_OFF;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      lat        <= lat_d;
      frame_tick <= tick_d;
      anode      <= lit_d ? (onehot_d ^ ANODE_OFF) : ANODE_OFF;
      seg        <= (state_d == ST_DRIVE) ? (lat_d ^ SEG_OFF) : SEG_OFF;
    end
  end

  assign digit_idx = idx;

endmodule
